float_to_fixed: RTL and testbench
=================================

Name: float_to_fixed

Overview:
- Streaming converter from IEEE-754 single precision to signed two's-complement fixed point.
- Sits directly downstream of float_add and consumes its vres result, so adder outputs can be fed to integer/fixed datapaths and to the display/debug logic.
- 2-stage pipeline with valid/ready handshake on both sides.
- Round-to-nearest-even, saturating, with per-result status flags.

Parameters:
- FRAC_BITS, 16, number of fractional bits in the output (output format Q(OUT_W-FRAC_BITS).FRAC_BITS); legal range 0..OUT_W-1.
- OUT_W, 32, output word width; legal range 8..32.

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  stage accepts in_data this cycle
- in_data  input  32  IEEE-754 single (e.g. float_add vres)
- out_valid  output  1  out_data/flags valid
- out_ready  input  1  downstream accepts this cycle
- out_data  output  OUT_W  signed fixed-point result
- out_ovf  output  1  result saturated (overflow or ±inf)
- out_nan  output  1  input was NaN
- out_inexact  output  1  nonzero bits discarded by rounding/flush

Behaviour:
- Reset: clk edge with rst=1 clears both stage valids. Outputs are out_valid=0, out_data=0, all flags 0. in_ready=1 in the cycle after reset. rst mid-stream drops all in-flight data without emitting it.
- Handshake:
  - advance = !out_valid | out_ready; in_ready = advance (global stall, no combinational in_valid->in_ready path).
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - With out_ready held 1, latency is 2 cycles and throughput is 1 per cycle.
  - While stalled, out_data and flags are held stable.
- Stage 1 (unpack):
  - s = bit31, e = bits30:23, m = {1,bits22:0}.
  - sh = e - 150 + FRAC_BITS (signed, 10 bits).
  - Classify: e=255 & frac≠0 → NaN; e=255 & frac=0 → inf; e=0 → zero (denormals flushed; inexact=1 if frac≠0).
  - If sh≥0: magnitude = m<<sh, computed in OUT_W+24 bits.
  - If sh<0: magnitude = m>>(-sh), with guard = first dropped bit and sticky = OR of the remaining dropped bits. -sh>25 gives magnitude 0, guard 0, sticky=1.
- Stage 2 (round/saturate):
  - Round up if guard & (sticky | lsb) (ties to even). inexact = guard|sticky.
  - Apply sign by two's-complement negation.
  - Positive limit 2^(OUT_W-1)-1; negative limit -2^(OUT_W-1). -2^(OUT_W-1) is exact and does not overflow.
  - Beyond a limit (after rounding): saturate, ovf=1.
  - +inf → max with ovf=1; -inf → min with ovf=1.
  - NaN → out_data=0, nan=1, ovf=0, inexact=0.
  - ±0 → 0, no flags.

Optional Feature:
- Macro FLOAT_TO_FIXED_STICKY_FLAGS_EN.
- When defined:
  - Adds input clr_sticky (1) and output sticky_flags (3, {nan,ovf,inexact}).
  - Each flag bit ORs in the flags of every output transfer.
  - clr_sticky=1 clears the bits at the next clk edge; a transfer in the same cycle still sets them (set wins).
  - rst clears sticky_flags.
- When undefined: neither port exists and no extra state is built.

Decomposition:
- Shared package float_pkg holds:
  - constants FP_EXP_BIAS=127, FP_MANT_W=23, FP_EXP_W=8, FP_EXP_MAX=255;
  - a packed struct fp32_t {sign, exp, frac};
  - a class enum {FP_ZERO, FP_NORM, FP_INF, FP_NAN}.
- float_add uses the same package.
- One natural sub-module: fp_round_sat (stage-2 combinational round, negate and saturate), instantiated once.

Test Plan (FRAC_BITS=16, OUT_W=32 unless noted):
- Reset: assert rst 3 cycles with in_valid=1 → out_valid=0, out_data=0, flags 0. First accepted word after release appears 2 cycles later.
- Rounding cases, out_ready=1:
  - 0x4145851F (12.345) → 0x000C5852, inexact=1.
  - 0x40490FDA → 0x0003243F, inexact=1.
  - 0xC0490FDA → 0xFFFCDBC1.
  - Back-to-back inputs give outputs on consecutive cycles.
- Ties to even: 0x37000000 (0.5 LSB) → 0x00000000, inexact=1; 0x37C00000 (1.5 LSB) → 0x00000002, inexact=1.
- Saturation:
  - 0x47000000 → 0x7FFFFFFF, ovf=1.
  - 0xC7000000 → 0x80000000, ovf=0.
  - 0xFF800000 → 0x80000000, ovf=1.
  - 0x7FC00000 → 0, nan=1.
- Backpressure: stream 4 values with out_ready toggled 1,0,0,1,… → no loss or duplication, in_ready low exactly while the pipe is full and stalled, held outputs stable.
- With FLOAT_TO_FIXED_STICKY_FLAGS_EN: send NaN then 1.0 (0x3F800000 → 0x00010000) → sticky_flags=3'b100. Then clr_sticky with a simultaneous 0x47000000 output transfer → 3'b010.

Source files
------------

// File: rtl/float_pkg.sv
// Shared IEEE-754 single-precision definitions used by float_add and float_to_fixed.
package float_pkg;

    localparam int FP_EXP_BIAS = 127;
    localparam int FP_MANT_W   = 23;
    localparam int FP_EXP_W    = 8;
    localparam int FP_EXP_MAX  = 255;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

    // Denormals are classed as zero; callers flush them.
    function automatic fp_class_e fp_classify(input fp32_t f);
        if (f.exp == FP_EXP_W'(FP_EXP_MAX))
            return (f.frac != '0) ? FP_NAN : FP_INF;
        else if (f.exp == '0)
            return FP_ZERO;
        else
            return FP_NORM;
    endfunction

endpackage

// File: rtl/fp_round_sat.sv
// Stage-2 combinational logic of float_to_fixed: round-to-nearest-even, apply sign, saturate.
module fp_round_sat
    import float_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  fp_class_e          cls,
    input  logic               sign,
    input  logic [OUT_W+23:0]  mag,
    input  logic               guard,
    input  logic               sticky,
    output logic [OUT_W-1:0]   data,
    output logic               ovf,
    output logic               nan,
    output logic               inexact
);

    localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    logic              round_up;
    logic [OUT_W+24:0] rounded;
    logic              too_big;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        data    = '0;
        ovf     = 1'b0;
        nan     = 1'b0;
        inexact = 1'b0;

        round_up = guard & (sticky | mag[0]);
        rounded  = {1'b0, mag} + (OUT_W+25)'(round_up);
        // The negative side may reach exactly 2^(OUT_W-1) without overflowing.
        too_big  = sign ? (rounded > (OUT_W+25)'(MIN_NEG))
                        : (rounded > (OUT_W+25)'(MAX_POS));

        case (cls)
            FP_NAN: nan = 1'b1;
            FP_INF: begin
                ovf  = 1'b1;
                data = sign ? MIN_NEG : MAX_POS;
            end
            default: begin
                inexact = guard | sticky;
                if (too_big) begin
                    ovf  = 1'b1;
                    data = sign ? MIN_NEG : MAX_POS;
                end else begin
                    data = sign ? -rounded[OUT_W-1:0] : rounded[OUT_W-1:0];
                end
            end
        endcase
    end

endmodule

// File: rtl/float_to_fixed.sv
// Two-stage streaming IEEE-754 single to signed Q(OUT_W-FRAC_BITS).FRAC_BITS converter.
// Optional FLOAT_TO_FIXED_STICKY_FLAGS_EN adds clr_sticky / sticky_flags accumulation.
module float_to_fixed
    import float_pkg::*;
#(
    parameter int FRAC_BITS = 16,
    parameter int OUT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic             out_nan,
    output logic             out_inexact
`ifdef FLOAT_TO_FIXED_STICKY_FLAGS_EN
    ,
    input  logic             clr_sticky,
    output logic [2:0]       sticky_flags
`endif
);

    localparam int MAG_W = OUT_W + 24;

    fp32_t in_fp;
    logic  advance;

    assign in_fp    = in_data;
    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;

    logic signed [9:0] sh;
    logic [9:0]        rsh;
    logic [4:0]        rsh5;
    logic [24:0]       m_ext;
    logic [24:0]       drop_mask;
    fp_class_e         cls_c;
    logic [MAG_W-1:0]  mag_c;
    logic              guard_c;
    logic              sticky_c;

    always_comb begin
        sh = $signed({2'b00, in_fp.exp}) - $signed(10'(FP_EXP_BIAS + FP_MANT_W))
           + $signed(10'(FRAC_BITS));
        rsh       = -sh;
        rsh5      = rsh[4:0];
        m_ext     = {2'b01, in_fp.frac};
        drop_mask = (25'd1 << rsh5) - 25'd1;
        cls_c     = fp_classify(in_fp);
        mag_c     = '0;
        guard_c   = 1'b0;
        sticky_c  = 1'b0;

        case (cls_c)
            FP_ZERO: sticky_c = |in_fp.frac;
            FP_NORM: begin
                if (!sh[9]) begin
                    // Shifts past OUT_W cannot fit; all-ones forces saturation downstream.
                    if ($unsigned(sh) > 10'(OUT_W))
                        mag_c = '1;
                    else
                        mag_c = MAG_W'(m_ext[23:0]) << sh[5:0];
                end else if (rsh > 10'd25) begin
                    sticky_c = 1'b1;
                end else begin
                    mag_c    = MAG_W'(m_ext >> rsh5);
                    guard_c  = |(m_ext & (drop_mask ^ (drop_mask >> 1)));
                    sticky_c = |(m_ext & (drop_mask >> 1));
                end
            end
            default: ;
        endcase
    end

    logic             s1_valid;
    fp_class_e        s1_cls;
    logic             s1_sign;
    logic [MAG_W-1:0] s1_mag;
    logic             s1_guard;
    logic             s1_sticky;

    logic [OUT_W-1:0] rs_data;
    logic             rs_ovf;
    logic             rs_nan;
    logic             rs_inexact;

    fp_round_sat #(.OUT_W(OUT_W)) u_round_sat (
        .cls     (s1_cls),
        .sign    (s1_sign),
        .mag     (s1_mag),
        .guard   (s1_guard),
        .sticky  (s1_sticky),
        .data    (rs_data),
        .ovf     (rs_ovf),
        .nan     (rs_nan),
        .inexact (rs_inexact)
    );

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_ovf     <= 1'b0;
            out_nan     <= 1'b0;
            out_inexact <= 1'b0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data    <= rs_data;
                out_ovf     <= rs_ovf;
                out_nan     <= rs_nan;
                out_inexact <= rs_inexact;
            end
        end
    end

    // NOTE: stage-1 payload needs no reset; it is only consumed behind s1_valid.
    always_ff @(posedge clk) begin
        if (advance && in_valid) begin
            s1_cls    <= cls_c;
            s1_sign   <= in_fp.sign;
            s1_mag    <= mag_c;
            s1_guard  <= guard_c;
            s1_sticky <= sticky_c;
        end
    end

`ifdef FLOAT_TO_FIXED_STICKY_FLAGS_EN
    logic out_fire;
    assign out_fire = out_valid & out_ready;

    // A transfer in the clearing cycle still sets its flags.
    always_ff @(posedge clk) begin
        if (rst)
            sticky_flags <= 3'b000;
        else
            sticky_flags <= (clr_sticky ? 3'b000 : sticky_flags)
                          | (out_fire ? {out_nan, out_ovf, out_inexact} : 3'b000);
    end
`endif

endmodule

// File: tb/tb_float_to_fixed.sv
// Directed self-checking bench for float_to_fixed (FRAC_BITS=16, OUT_W=32).
module tb_float_to_fixed;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        out_nan;
    logic        out_inexact;
`ifdef FLOAT_TO_FIXED_STICKY_FLAGS_EN
    logic        clr_sticky;
    logic [2:0]  sticky_flags;
`endif

    always #5 clk = ~clk;

    float_to_fixed #(.FRAC_BITS(16), .OUT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ovf     (out_ovf),
        .out_nan     (out_nan),
        .out_inexact (out_inexact)
`ifdef FLOAT_TO_FIXED_STICKY_FLAGS_EN
        ,
        .clr_sticky  (clr_sticky),
        .sticky_flags(sticky_flags)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam int N = 14;
    // Flags below are {nan, ovf, inexact}.
    logic [31:0] vin  [N] = '{32'h4145851F, 32'h40490FDA, 32'hC0490FDA, 32'h37000000,
                              32'h37C00000, 32'h47000000, 32'hC7000000, 32'hFF800000,
                              32'h7FC00000, 32'h3F800000, 32'h00000000, 32'h80000001,
                              32'h7F000000, 32'h33800000};
    logic [31:0] vexp [N] = '{32'h000C5852, 32'h0003243F, 32'hFFFCDBC1, 32'h00000000,
                              32'h00000002, 32'h7FFFFFFF, 32'h80000000, 32'h80000000,
                              32'h00000000, 32'h00010000, 32'h00000000, 32'h00000000,
                              32'h7FFFFFFF, 32'h00000000};
    logic [2:0]  vflg [N] = '{3'b001, 3'b001, 3'b001, 3'b001,
                              3'b001, 3'b010, 3'b000, 3'b010,
                              3'b100, 3'b000, 3'b000, 3'b001,
                              3'b010, 3'b001};

    logic [31:0] bp_in  [4] = '{32'h3F800000, 32'h40490FDA, 32'hC0490FDA, 32'h37C00000};
    logic [31:0] bp_exp [4] = '{32'h00010000, 32'h0003243F, 32'hFFFCDBC1, 32'h00000002};

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sent;
        int          rx;
        logic        m1_v;
        logic        m2_v;
        logic        stalled_prev;
        logic [31:0] held;

        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h3F800000;
        out_ready = 1'b1;
`ifdef FLOAT_TO_FIXED_STICKY_FLAGS_EN
        clr_sticky = 1'b0;
`endif
        repeat (3) begin
            tick();
            check("rst_valid", out_valid, 1'b0);
            check("rst_data", out_data, 32'h0);
            check("rst_flags", {out_nan, out_ovf, out_inexact}, 3'b000);
        end
        rst = 1'b0;
        check("ready_after_rst", in_ready, 1'b1);

        // Back-to-back stream: result of vector i-1 is visible after edge i.
        for (int i = 0; i <= N; i++) begin
            if (i < N) begin
                in_valid = 1'b1;
                in_data  = vin[i];
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i == 0) begin
                check("latency_first", out_valid, 1'b0);
            end else begin
                check($sformatf("vec%0d_valid", i-1), out_valid, 1'b1);
                check($sformatf("vec%0d_data", i-1), out_data, vexp[i-1]);
                check($sformatf("vec%0d_flags", i-1), {out_nan, out_ovf, out_inexact}, vflg[i-1]);
            end
        end
        tick();
        check("drain_valid", out_valid, 1'b0);

        // Reset with a word in flight must drop it.
        in_valid = 1'b1;
        in_data  = 32'h3F800000;
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid0", out_valid, 1'b0);
        tick();
        check("midrst_valid1", out_valid, 1'b0);
        tick();
        check("midrst_valid2", out_valid, 1'b0);

        // Backpressure with out_ready pattern 1,0,0,1.
        sent         = 0;
        rx           = 0;
        m1_v         = 1'b0;
        m2_v         = 1'b0;
        stalled_prev = 1'b0;
        held         = '0;
        for (int c = 0; c < 40 && rx < 4; c++) begin
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            in_valid  = (sent < 4);
            in_data   = bp_in[(sent < 4) ? sent : 0];
            #1;
            check("bp_ready", in_ready, !m2_v || out_ready);
            check("bp_valid", out_valid, m2_v);
            if (stalled_prev)
                check("bp_hold", out_data, held);
            if (out_valid && out_ready) begin
                check($sformatf("bp_data%0d", rx), out_data, bp_exp[rx]);
                rx++;
            end
            stalled_prev = out_valid && !out_ready;
            held         = out_data;
            if (!m2_v || out_ready) begin
                m2_v = m1_v;
                m1_v = in_valid;
                if (in_valid) sent++;
            end
            tick();
        end
        check("bp_count", rx, 4);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

`ifdef FLOAT_TO_FIXED_STICKY_FLAGS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("sticky_rst", sticky_flags, 3'b000);
        in_valid = 1'b1;
        in_data  = 32'h7FC00000;
        tick();
        in_data  = 32'h3F800000;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("sticky_nan", sticky_flags, 3'b100);
        in_valid = 1'b1;
        in_data  = 32'h47000000;
        tick();
        in_valid = 1'b0;
        tick();
        check("sticky_before_clr", sticky_flags, 3'b100);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("sticky_clr_set", sticky_flags, 3'b010);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
